// File: rtl/execute_stage.sv
// Execute unit: single-cycle ALU plus a one-bit-per-cycle shifter, both writing into DR and SZCV.
// Build option SHIFT_FAST_EN swaps the iterative shifter for a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | ready for start; ALU ops (and every op when SHIFT_FAST_EN) complete here in one edge
// SHIFT | iterative shift in progress; start is ignored until the last bit is out
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op3,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [3:0]       shamt,
    output logic             busy,
    output logic             done,
    output logic             wb_en,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [1:0]       sop, sop_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [3:0]       flags_nxt;
    logic             done_nxt, wb_nxt;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_upd, alu_wr, alu_wb;
    logic             go_shift;

    logic [WIDTH-1:0] step_res;
    logic             step_c;

`ifdef SHIFT_FAST_EN
    logic [WIDTH:0]   sh_l, sh_r, sh_a;
    logic [WIDTH-1:0] rot;
    int               rot_amt;
`endif

    assign busy = (state == SHIFT);

    always_comb begin
        sum     = {1'b0, data_a} + {1'b0, data_b};
        diff    = {1'b0, data_a} - {1'b0, data_b};
        alu_res = result;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b1;
        alu_wr  = 1'b1;
        alu_wb  = 1'b1;
`ifdef SHIFT_FAST_EN
        // Extra bit beside the operand catches the last bit shifted out.
        sh_l    = {1'b0, data_a} << shamt;
        sh_r    = {data_a, 1'b0} >> shamt;
        sh_a    = $signed({data_a, 1'b0}) >>> shamt;
        rot_amt = int'(shamt) % WIDTH;
        rot     = (data_a << rot_amt) | (data_a >> (WIDTH - rot_amt));
`endif
        case (op3)
            4'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                          (sum[WIDTH-1] != data_a[WIDTH-1]);
            end
            4'd1, 4'd5: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                          (diff[WIDTH-1] != data_a[WIDTH-1]);
                if (op3 == 4'd5) begin
                    alu_wr = 1'b0;
                    alu_wb = 1'b0;
                end
            end
            4'd2: alu_res = data_a & data_b;
            4'd3: alu_res = data_a | data_b;
            4'd4: alu_res = data_a ^ data_b;
            4'd6: alu_res = data_b;
`ifdef SHIFT_FAST_EN
            4'd8: begin
                alu_res = sh_l[WIDTH-1:0];
                alu_c   = sh_l[WIDTH];
            end
            4'd9: begin
                alu_res = rot;
                alu_c   = (shamt != 4'd0) && rot[0];
            end
            4'd10: begin
                alu_res = sh_r[WIDTH:1];
                alu_c   = sh_r[0];
            end
            4'd11: begin
                alu_res = sh_a[WIDTH:1];
                alu_c   = sh_a[0];
            end
`else
            // Only reached with shamt == 0; non-zero amounts go to SHIFT.
            4'd8, 4'd9, 4'd10, 4'd11: alu_res = data_a;
`endif
            default: begin
                alu_upd = 1'b0;
                alu_wr  = 1'b0;
                alu_wb  = 1'b0;
            end
        endcase
    end

`ifdef SHIFT_FAST_EN
    assign go_shift = 1'b0;
`else
    assign go_shift = (op3[3:2] == 2'b10) && (shamt != 4'd0);
`endif

    always_comb begin
        step_res = work;
        step_c   = 1'b0;
        case (sop)
            2'd0: begin
                step_res = {work[WIDTH-2:0], 1'b0};
                step_c   = work[WIDTH-1];
            end
            2'd1: begin
                step_res = {work[WIDTH-2:0], work[WIDTH-1]};
                step_c   = work[WIDTH-1];
            end
            2'd2: begin
                step_res = {1'b0, work[WIDTH-1:1]};
                step_c   = work[0];
            end
            default: begin
                step_res = {work[WIDTH-1], work[WIDTH-1:1]};
                step_c   = work[0];
            end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        work_nxt   = work;
        sop_nxt    = sop;
        result_nxt = result;
        flags_nxt  = flags;
        done_nxt   = 1'b0;
        wb_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (go_shift) begin
                        state_nxt = SHIFT;
                        work_nxt  = data_a;
                        cnt_nxt   = shamt;
                        sop_nxt   = op3[1:0];
                    end else begin
                        done_nxt = 1'b1;
                        wb_nxt   = alu_wb;
                        if (alu_wr) result_nxt = alu_res;
                        if (alu_upd) begin
                            flags_nxt = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
                        end
                    end
                end
            end
            SHIFT: begin
                work_nxt = step_res;
                // Terminal count: this edge shifts the final bit.
                if (cnt == 4'd1) begin
                    state_nxt  = IDLE;
                    result_nxt = step_res;
                    flags_nxt  = {step_res[WIDTH-1], (step_res == '0), step_c, 1'b0};
                    done_nxt   = 1'b1;
                    wb_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            work   <= '0;
            sop    <= '0;
            result <= '0;
            flags  <= '0;
            done   <= 1'b0;
            wb_en  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            work   <= work_nxt;
            sop    <= sop_nxt;
            result <= result_nxt;
            flags  <= flags_nxt;
            done   <= done_nxt;
            wb_en  <= wb_nxt;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases, a reset abort and randomized ops against an arithmetic model.
module tb_execute_stage;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    op3;
    logic [W-1:0]  data_a, data_b;
    logic [3:0]    shamt;
    logic          busy, done, wb_en;
    logic [W-1:0]  result;
    logic [3:0]    flags;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_result;
    logic [3:0]   exp_flags;

    execute_stage #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .op3(op3),
        .data_a(data_a), .data_b(data_b), .shamt(shamt),
        .busy(busy), .done(done), .wb_en(wb_en), .result(result), .flags(flags)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: computes each op from its arithmetic meaning.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] sh, output bit upd, output bit wr, output bit wb,
                                  output logic [W-1:0] r, output bit c, output bit v);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        int n = int'(sh);
        int m;
        upd = 1; wr = 1; wb = 1; c = 0; v = 0; r = '0;
        case (op)
            0: begin
                t = ua + ub; r = W'(t); c = (t > 65535);
                t = sa + sb; v = (t > 32767) || (t < -32768);
            end
            1, 5: begin
                r = W'(ua - ub); c = (ua < ub);
                t = sa - sb; v = (t > 32767) || (t < -32768);
                if (op == 5) begin wr = 0; wb = 0; end
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            6: r = b;
            8: begin
                r = W'(ua * (longint'(1) << n));
                c = (n != 0) && (((ua >> (W - n)) & 1) != 0);
            end
            9: begin
                m = n % W;
                r = W'((ua << m) | (ua >> (W - m)));
                c = (n != 0) && r[0];
            end
            10: begin
                r = W'(ua >> n);
                c = (n != 0) && (((ua >> (n - 1)) & 1) != 0);
            end
            11: begin
                r = W'(sa >>> n);
                c = (n != 0) && (((sa >>> (n - 1)) & 1) != 0);
            end
            default: begin upd = 0; wr = 0; wb = 0; end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] sh, input bit poke);
        bit upd, wr, wb, c, v, is_sh, poked;
        logic [W-1:0] r;
        int lat, busy_cnt, exp_lat, exp_busy;
        model(op, a, b, sh, upd, wr, wb, r, c, v);
`ifdef SHIFT_FAST_EN
        is_sh = 0;
`else
        is_sh = (op >= 8) && (op <= 11) && (sh != 0);
`endif
        exp_lat  = is_sh ? int'(sh) + 1 : 1;
        exp_busy = is_sh ? int'(sh) : 0;
        if (wr) exp_result = r;
        if (upd) exp_flags = {r[W-1], (r == '0), c, v};

        start = 1; op3 = op; data_a = a; data_b = b; shamt = sh;
        @(posedge clock); @(negedge clock);
        start = 0; op3 = 4'($urandom); data_a = W'($urandom); data_b = W'($urandom); shamt = 4'($urandom);
        lat = 1; busy_cnt = 0; poked = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (poke && !poked && busy_cnt == 2) begin
                start = 1; op3 = 4'd0; data_a = W'($urandom); data_b = W'($urandom);
                poked = 1;
            end
            @(posedge clock); @(negedge clock);
            start = 0;
            lat++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_wb"}, 32'(wb_en), 32'(wb));
        check({tag, "_res"}, 32'(result), 32'(exp_result));
        check({tag, "_flags"}, 32'(flags), 32'(exp_flags));
        if (poke) begin
            @(negedge clock);
            check({tag, "_one_done"}, 32'(done), 32'd0);
            check({tag, "_res_hold"}, 32'(result), 32'(exp_result));
        end
    endtask

    initial begin
        int bc;
        logic [3:0] rop, rsh;
        reset = 0; start = 0; op3 = 0; data_a = 0; data_b = 0; shamt = 0;
        exp_result = '0; exp_flags = '0;
        #1;
        check("rst_res", 32'(result), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        repeat (2) @(negedge clock);
        reset = 1;
        @(negedge clock);

        do_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 4'd0, 0);
        do_op("sub_neg", 4'd1, 16'h0003, 16'h0005, 4'd0, 0);
        do_op("cmp_eq", 4'd5, 16'h1234, 16'h1234, 4'd0, 0);
        check("cmp_res_kept", 32'(result), 32'h0000FFFE);
        do_op("sra3", 4'd11, 16'h8001, 16'h0000, 4'd3, 0);
        check("sra3_val", 32'(result), 32'h0000F000);
        do_op("sll1", 4'd8, 16'h8001, 16'h0000, 4'd1, 0);
        check("sll1_val", 32'(flags[1]), 1);
        do_op("slr4_poke", 4'd9, 16'h8001, 16'h0000, 4'd4, 1);
        check("slr4_val", 32'(result), 32'h00000018);
        do_op("nop7", 4'd7, 16'hFFFF, 16'hFFFF, 4'd0, 0);

        // Reset in the middle of a long shift.
        start = 1; op3 = 4'd10; data_a = 16'hFFFF; shamt = 4'd15;
        @(posedge clock); @(negedge clock);
        start = 0;
        bc = 1;
        while (bc < 5) begin
            @(posedge clock); @(negedge clock);
            if (busy) bc++; else bc = 99;
        end
        check("abort_reached", bc, 5);
        reset = 0;
        #1;
        check("abort_res", 32'(result), 0);
        check("abort_flags", 32'(flags), 0);
        check("abort_busy", 32'(busy), 0);
        exp_result = '0; exp_flags = '0;
        repeat (2) begin
            @(negedge clock);
            check("abort_nodone", 32'(done), 0);
        end
        reset = 1;
        repeat (18) begin
            @(negedge clock);
            check("abort_quiet", 32'(done), 0);
        end
        do_op("mov", 4'd6, 16'h5555, 16'h00A5, 4'd0, 0);
        do_op("srl0", 4'd10, 16'h1234, 16'h0000, 4'd0, 0);
        do_op("sra3_again", 4'd11, 16'h8001, 16'h0000, 4'd3, 0);

        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom);
            rsh = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            do_op($sformatf("rnd%0d", i), rop, W'($urandom), W'($urandom), rsh,
                  ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) @(negedge clock);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
